// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: size codes, exception causes,
// FSM states and the latched request record.
package lsu_pkg;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;
    localparam logic [1:0] LSU_SIZE_X = 2'b11;

    localparam logic [1:0] LSU_EXC_MISALIGN = 2'd0;
    localparam logic [1:0] LSU_EXC_BUSERR   = 2'd1;
    localparam logic [1:0] LSU_EXC_TIMEOUT  = 2'd2;
    localparam logic [1:0] LSU_EXC_BADSIZE  = 2'd3;

    typedef enum logic [1:0] {
        LSU_ST_IDLE = 2'd0,
        LSU_ST_CMD  = 2'd1,
        LSU_ST_RSP  = 2'd2,
        LSU_ST_DONE = 2'd3
    } lsu_state_e;

    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        is_unsigned;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
    } lsu_req_t;

    function automatic logic lsu_misaligned(logic [1:0] size, logic [1:0] lo);
        return ((size == LSU_SIZE_H) && lo[0]) || ((size == LSU_SIZE_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store enables/replication and load
// extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_data,
    output logic [3:0]  be,
    output logic [31:0] wr_data,
    output logic [31:0] ld_data
);

    logic [31:0] sh;

    always_comb begin
        be      = 4'b0000;
        wr_data = st_data;
        ld_data = 32'd0;
        sh      = rd_data >> {addr_lo, 3'b000};
        case (size)
            LSU_SIZE_B: begin
                be      = 4'b0001 << addr_lo;
                wr_data = {4{st_data[7:0]}};
                ld_data = is_unsigned ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            LSU_SIZE_H: begin
                be      = 4'b0011 << addr_lo;
                wr_data = {2{st_data[15:0]}};
                ld_data = is_unsigned ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            LSU_SIZE_W: begin
                be      = 4'b1111;
                ld_data = rd_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Blocking load/store unit: one bus transaction at a time, returning either
// a writeback pulse or an exception pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        bus_cmd_valid,
    input  logic        bus_cmd_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic        exc_store,
    output logic [31:0] exc_addr
);

    localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

    lsu_state_e  state, state_nxt;
    lsu_req_t    req_q;
    logic [7:0]  cnt;
    logic        exc_q, fault;
    logic [1:0]  cause_q, fault_cause;
    logic [31:0] data_q;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_ldata;
    logic        in_cmd, in_done;

    lsu_align u_align (
        .size        (req_q.size),
        .is_unsigned (req_q.is_unsigned),
        .addr_lo     (req_q.addr[1:0]),
        .st_data     (req_q.wdata),
        .rd_data     (bus_rsp_rdata),
        .be          (al_be),
        .wr_data     (al_wdata),
        .ld_data     (al_ldata)
    );

    always_comb begin
        state_nxt   = state;
        fault       = 1'b0;
        fault_cause = LSU_EXC_MISALIGN;
        case (state)
            LSU_ST_IDLE: if (req_valid) begin
                if (req_size == LSU_SIZE_X) begin
                    fault       = 1'b1;
                    fault_cause = LSU_EXC_BADSIZE;
                    state_nxt   = LSU_ST_DONE;
                end else if (lsu_misaligned(req_size, req_addr[1:0])) begin
                    fault     = 1'b1;
                    state_nxt = LSU_ST_DONE;
                end else begin
                    state_nxt = LSU_ST_CMD;
                end
            end
            LSU_ST_CMD: if (bus_cmd_ready) state_nxt = LSU_ST_RSP;
            // A response arriving while the counter sits at the limit still wins.
            LSU_ST_RSP: if (bus_rsp_valid) begin
                fault       = bus_rsp_err;
                fault_cause = LSU_EXC_BUSERR;
                state_nxt   = LSU_ST_DONE;
            end else if (cnt == TO_MAX) begin
                fault       = 1'b1;
                fault_cause = LSU_EXC_TIMEOUT;
                state_nxt   = LSU_ST_DONE;
            end
            LSU_ST_DONE: state_nxt = LSU_ST_IDLE;
            default:     state_nxt = LSU_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LSU_ST_IDLE;
            req_q   <= '0;
            cnt     <= 8'd0;
            exc_q   <= 1'b0;
            cause_q <= 2'd0;
            data_q  <= 32'd0;
        end else begin
            state <= state_nxt;
            case (state)
                LSU_ST_IDLE: if (req_valid) begin
                    req_q   <= '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                                 addr: req_addr, wdata: req_wdata, rd: req_rd};
                    exc_q   <= fault;
                    cause_q <= fault_cause;
                    data_q  <= 32'd0;
                end
                LSU_ST_CMD: if (bus_cmd_ready) cnt <= 8'd0;
                LSU_ST_RSP: if (state_nxt == LSU_ST_DONE) begin
                    exc_q   <= fault;
                    cause_q <= fault_cause;
                    if (bus_rsp_valid && !bus_rsp_err && !req_q.we) data_q <= al_ldata;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are gated by state so they read zero in reset and between ops.
    assign in_cmd        = (state == LSU_ST_CMD);
    assign in_done       = (state == LSU_ST_DONE);
    assign req_ready     = (state == LSU_ST_IDLE);
    assign bus_cmd_valid = in_cmd;
    assign bus_addr      = in_cmd ? {req_q.addr[31:2], 2'b00} : 32'd0;
    assign bus_we        = in_cmd & req_q.we;
    assign bus_be        = in_cmd ? al_be : 4'b0000;
    assign bus_wdata     = in_cmd ? al_wdata : 32'd0;
    assign wb_valid      = in_done & ~exc_q;
    assign wb_we         = wb_valid & ~req_q.we;
    assign wb_rd         = wb_valid ? req_q.rd : 5'd0;
    assign wb_data       = wb_valid ? data_q : 32'd0;
    assign exc_valid     = in_done & exc_q;
    assign exc_cause     = exc_valid ? cause_q : 2'd0;
    assign exc_store     = exc_valid & req_q.we;
    assign exc_addr      = exc_valid ? req_q.addr : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: scoreboard of expected completions, bus responder
// forked alongside each request.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        bus_cmd_valid, bus_cmd_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rsp_rdata;
    logic [3:0]  bus_be;
    logic        bus_rsp_valid, bus_rsp_err;
    logic        wb_valid, wb_we, exc_valid, exc_store;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, exc_addr;
    logic [1:0]  exc_cause;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          exc;
        logic [1:0]  cause;
        bit          store;
        logic [31:0] addr;
        bit          we;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata), .bus_rsp_err(bus_rsp_err),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_store(exc_store), .exc_addr(exc_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Enable lanes covering [lo, lo+n).
    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [1:0] lo);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (i >= int'(lo)) && (i < int'(lo) + nbytes(size));
        return r;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nbytes(size)) +: 8];
        return r;
    endfunction

    task automatic push_wb(input bit we, input logic [4:0] rd, input logic [31:0] data);
        exp_t e;
        e = '{exc: 1'b0, cause: 2'd0, store: 1'b0, addr: 32'd0, we: !we, rd: rd, data: data};
        sb.push_back(e);
    endtask

    task automatic push_exc(input logic [1:0] cause, input bit store, input logic [31:0] addr);
        exp_t e;
        e = '{exc: 1'b1, cause: cause, store: store, addr: addr, we: 1'b0, rd: 5'd0, data: 32'd0};
        sb.push_back(e);
    endtask

    task automatic check_fields(input string tag, input bit we, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
        chk({tag, ".bus_addr"}, bus_addr, {addr[31:2], 2'b00});
        chk({tag, ".bus_we"}, {31'd0, bus_we}, {31'd0, we});
        chk({tag, ".bus_be"}, {28'd0, bus_be}, {28'd0, m_be(size, addr[1:0])});
        if (we) chk({tag, ".bus_wdata"}, bus_wdata, m_wdata(size, wdata));
    endtask

    // Called at a negedge with the unit idle; returns at a negedge with it idle again.
    task automatic run_op(input string tag, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int rdy_lat, input int rsp_lat, input bit err, input bit no_rsp,
                          input logic [31:0] rdata, input bit expect_cmd, input int exp_cyc);
        fork
            begin : requester
                int n;
                int cmd_seen;
                exp_t e;
                n = 0;
                cmd_seen = 0;
                req_we = we; req_size = size; req_unsigned = uns;
                req_addr = addr; req_wdata = wdata; req_rd = rd; req_valid = 1'b1;
                @(posedge clk);
                #1 req_valid = 1'b0;
                while (n < 300) begin
                    @(negedge clk);
                    n++;
                    if (bus_cmd_valid) cmd_seen++;
                    if (wb_valid || exc_valid) break;
                end
                chk({tag, ".latency"}, n, exp_cyc);
                if (!expect_cmd) chk({tag, ".no_cmd"}, cmd_seen, 0);
                chk({tag, ".sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, !e.exc});
                    chk({tag, ".exc_valid"}, {31'd0, exc_valid}, {31'd0, e.exc});
                    chk({tag, ".wb_we"}, {31'd0, wb_we}, {31'd0, e.we});
                    if (e.exc) begin
                        chk({tag, ".exc_cause"}, {30'd0, exc_cause}, {30'd0, e.cause});
                        chk({tag, ".exc_store"}, {31'd0, exc_store}, {31'd0, e.store});
                        chk({tag, ".exc_addr"}, exc_addr, e.addr);
                    end else begin
                        chk({tag, ".wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
                        chk({tag, ".wb_data"}, wb_data, e.data);
                    end
                end
                @(negedge clk);
                chk({tag, ".pulse_1cyc"}, {31'd0, wb_valid | exc_valid}, 32'd0);
                chk({tag, ".ready_after"}, {31'd0, req_ready}, 32'd1);
            end
            begin : responder
                int k;
                if (expect_cmd) begin
                    k = 0;
                    while (!bus_cmd_valid && k < 20) begin
                        @(negedge clk);
                        k++;
                    end
                    chk({tag, ".cmd_valid"}, {31'd0, bus_cmd_valid}, 32'd1);
                    if (bus_cmd_valid) begin
                        for (int i = 0; i < rdy_lat; i++) begin
                            check_fields(tag, we, size, addr, wdata);
                            @(negedge clk);
                        end
                        check_fields(tag, we, size, addr, wdata);
                        bus_cmd_ready = 1'b1;
                        @(negedge clk);
                        bus_cmd_ready = 1'b0;
                        if (!no_rsp) begin
                            repeat (rsp_lat) @(negedge clk);
                            bus_rsp_valid = 1'b1;
                            bus_rsp_err   = err;
                            bus_rsp_rdata = rdata;
                            @(negedge clk);
                            bus_rsp_valid = 1'b0;
                            bus_rsp_err   = 1'b0;
                        end
                    end
                end
            end
        join
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        bus_cmd_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'd0; bus_rsp_err = 1'b0;

        #1;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst.cmd_valid", {31'd0, bus_cmd_valid}, 32'd0);
        chk("rst.bus_be", {28'd0, bus_be}, 32'd0);
        chk("rst.bus_addr", bus_addr, 32'd0);
        chk("rst.pulses", {31'd0, wb_valid | exc_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        push_wb(1'b0, 5'd5, 32'h8765_4321);
        run_op("lw", 1'b0, 2'b10, 1'b0, 32'h1000, 32'd0, 5'd5, 0, 0, 1'b0, 1'b0, 32'h8765_4321, 1'b1, 3);
        push_wb(1'b0, 5'd6, 32'hFFFF_FF80);
        run_op("lb", 1'b0, 2'b00, 1'b0, 32'h1003, 32'd0, 5'd6, 0, 0, 1'b0, 1'b0, 32'h8012_3456, 1'b1, 3);
        push_wb(1'b0, 5'd6, 32'h0000_0080);
        run_op("lbu", 1'b0, 2'b00, 1'b1, 32'h1003, 32'd0, 5'd6, 0, 0, 1'b0, 1'b0, 32'h8012_3456, 1'b1, 3);
        push_wb(1'b1, 5'd7, 32'd0);
        run_op("sh", 1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234_ABCD, 5'd7, 3, 0, 1'b0, 1'b0, 32'd0, 1'b1, 6);
        push_wb(1'b0, 5'd8, 32'hFFFF_8001);
        run_op("lh", 1'b0, 2'b01, 1'b0, 32'h2002, 32'd0, 5'd8, 0, 0, 1'b0, 1'b0, 32'h8001_1234, 1'b1, 3);
        push_wb(1'b0, 5'd8, 32'h0000_F00F);
        run_op("lhu", 1'b0, 2'b01, 1'b1, 32'h2000, 32'd0, 5'd8, 1, 2, 1'b0, 1'b0, 32'h1234_F00F, 1'b1, 6);
        push_wb(1'b1, 5'd3, 32'd0);
        run_op("sb", 1'b1, 2'b00, 1'b0, 32'h5001, 32'h0000_00A5, 5'd3, 0, 0, 1'b0, 1'b0, 32'd0, 1'b1, 3);
        push_exc(2'd0, 1'b0, 32'h3001);
        run_op("lw_mis", 1'b0, 2'b10, 1'b0, 32'h3001, 32'd0, 5'd1, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1);
        push_exc(2'd0, 1'b1, 32'h5002);
        run_op("sw_mis", 1'b1, 2'b10, 1'b0, 32'h5002, 32'd0, 5'd1, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1);
        push_exc(2'd3, 1'b1, 32'h4000);
        run_op("badsize", 1'b1, 2'b11, 1'b0, 32'h4000, 32'd0, 5'd1, 0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 1);
        push_exc(2'd2, 1'b0, 32'h6000);
        run_op("timeout", 1'b0, 2'b10, 1'b0, 32'h6000, 32'd0, 5'd9, 0, 0, 1'b0, 1'b1, 32'd0, 1'b1, 7);

        // late response while idle must be ignored
        bus_rsp_valid = 1'b1;
        bus_rsp_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus_rsp_valid = 1'b0;
        chk("late.ready", {31'd0, req_ready}, 32'd1);
        chk("late.pulse0", {31'd0, wb_valid | exc_valid}, 32'd0);
        @(negedge clk);
        chk("late.pulse1", {31'd0, wb_valid | exc_valid}, 32'd0);

        push_exc(2'd1, 1'b0, 32'h7000);
        run_op("buserr", 1'b0, 2'b10, 1'b0, 32'h7000, 32'd0, 5'd4, 0, 1, 1'b1, 1'b0, 32'd0, 1'b1, 4);
        push_wb(1'b0, 5'd10, 32'h0BAD_F00D);
        run_op("rsp_at_limit", 1'b0, 2'b10, 1'b0, 32'h7004, 32'd0, 5'd10, 0, 4, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b1, 7);

        // reset while a command is outstanding
        req_we = 1'b0; req_size = 2'b10; req_addr = 32'h8000; req_rd = 5'd2; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("mid.cmd_valid", {31'd0, bus_cmd_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.cmd_drop", {31'd0, bus_cmd_valid}, 32'd0);
        chk("mid.ready", {31'd0, req_ready}, 32'd1);
        chk("mid.bus_addr", bus_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (4) begin
            @(negedge clk);
            if (wb_valid || exc_valid || bus_cmd_valid) pulses++;
        end
        chk("mid.no_activity", pulses, 0);

        push_wb(1'b0, 5'd11, 32'h0000_0055);
        run_op("post_rst", 1'b0, 2'b00, 1'b1, 32'h9002, 32'd0, 5'd11, 0, 0, 1'b0, 1'b0, 32'h0055_0000, 1'b1, 3);

        chk("sb.drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
